ahb_slave_control: RTL and testbench

AHB_SLAVE_CONTROL -- requirements
Module: ahb_slave_control

---
 rtl/ahb_slave_control.sv | 128 ++++++++++++
 tb/tb_ahb_slave_control.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_control.sv
// AHB slave transfer controller: accepts transfers, screens illegal accesses, stalls reads on a busy buffer.
// Optional misaligned-access screening is enabled by defining AHB_SLAVE_MISALIGN_CHECK_EN.
module ahb_slave_control #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsel,
    input  logic [1:0] htrans,
    input  logic       hwrite,
    input  logic [3:0] haddr,
    input  logic [1:0] hsize,
    input  logic       buffer_busy,
    output logic [3:0] haddr_reg,
    output logic [1:0] hsize_reg,
    output logic       wr_en,
    output logic       rd_en,
    output logic       hready,
    output logic       hresp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state;
    state_t     state_next;
    logic       hwrite_reg;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       illegal;
    logic       buf_read;
    logic       unused_htrans;

    // Only htrans[1] distinguishes active (NONSEQ/SEQ) from IDLE/BUSY.
    assign unused_htrans = htrans[0];

    // Addresses 0-3 are served from the data buffer and may stall on reads.
    assign buf_read = !hwrite_reg && (haddr_reg < 4'd4);

    always_comb begin
        illegal = 1'b0;
        if (haddr inside {[4'h9:4'hB], [4'hE:4'hF]})
            illegal = 1'b1;
        if (hwrite && (haddr inside {[4'h4:4'h8]}))
            illegal = 1'b1;
        if (hsize == 2'd3)
            illegal = 1'b1;
`ifdef AHB_SLAVE_MISALIGN_CHECK_EN
        if ((hsize == 2'd2 && haddr[1:0] != 2'b00) || (hsize == 2'd1 && haddr[0]))
            illegal = 1'b1;
`endif
    end

    always_comb begin
        state_next = state;
        hready     = 1'b1;
        hresp      = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        case (state)
            S_IDLE: state_next = S_IDLE;
            S_DATA: begin
                if (buf_read && buffer_busy) begin
                    hready     = 1'b0;
                    state_next = S_WAIT;
                end else begin
                    wr_en      = hwrite_reg;
                    rd_en      = !hwrite_reg;
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                hready = 1'b0;
                if (!buffer_busy)
                    state_next = S_DATA;
                else if (wait_cnt + 8'd1 == MAX_WAIT_C)
                    state_next = S_ERR1;
            end
            S_ERR1: begin
                hready     = 1'b0;
                hresp      = 1'b1;
                state_next = S_ERR2;
            end
            S_ERR2: begin
                hresp      = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // hready is low in every state that must not take a new transfer.
        accept = hsel && htrans[1] && hready;
        if (accept)
            state_next = illegal ? S_ERR1 : S_DATA;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            haddr_reg  <= '0;
            hsize_reg  <= '0;
            hwrite_reg <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                haddr_reg  <= haddr;
                hsize_reg  <= hsize;
                hwrite_reg <= hwrite;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (state == S_WAIT && buffer_busy)
            wait_cnt <= wait_cnt + 8'd1;
        else
            wait_cnt <= '0;
    end

endmodule

// File: tb/tb_ahb_slave_control.sv
// Self-checking bench for ahb_slave_control: transfer-level model plus directed literal checks.
module tb_ahb_slave_control;

    localparam int unsigned MAX_W = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       hsel;
    logic [1:0] htrans;
    logic       hwrite;
    logic [3:0] haddr;
    logic [1:0] hsize;
    logic       buffer_busy;
    logic [3:0] haddr_reg;
    logic [1:0] hsize_reg;
    logic       wr_en;
    logic       rd_en;
    logic       hready;
    logic       hresp;

    int total = 0;
    int bad   = 0;

    ahb_slave_control #(.MAX_WAIT(MAX_W)) dut (
        .clk(clk), .rst(rst), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .haddr(haddr), .hsize(hsize), .buffer_busy(buffer_busy),
        .haddr_reg(haddr_reg), .hsize_reg(hsize_reg), .wr_en(wr_en),
        .rd_en(rd_en), .hready(hready), .hresp(hresp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the transfer currently in its data phase and how long it has been held off.
    int         m_phase = 0;     // 0 none, 1 transfer, 2 error first cycle, 3 error second cycle
    bit         m_held  = 1'b0;  // read already stalled once and now waiting on the buffer
    int         m_waits = 0;
    logic [3:0] m_addr  = '0;
    logic [1:0] m_size  = '0;
    bit         m_write = 1'b0;
    bit         model_on = 1'b0;

    function automatic bit is_illegal(input int a, input int sz, input bit w);
        bit r;
        r = (a >= 9 && a <= 11) || a >= 14 || (w && a >= 4 && a <= 8) || sz == 3;
`ifdef AHB_SLAVE_MISALIGN_CHECK_EN
        r = r || (sz == 2 && a % 4 != 0) || (sz == 1 && a % 2 != 0);
`endif
        return r;
    endfunction

    function automatic bit read_stalls();
        return !m_write && m_addr < 4 && buffer_busy;
    endfunction

    task automatic expected(output bit e_rdy, output bit e_err, output bit e_wr, output bit e_rd);
        e_rdy = 1'b1; e_err = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
        if (m_phase == 1) begin
            if (m_held || read_stalls())
                e_rdy = 1'b0;
            else begin
                e_wr = m_write;
                e_rd = !m_write;
            end
        end else if (m_phase == 2) begin
            e_rdy = 1'b0; e_err = 1'b1;
        end else if (m_phase == 3) begin
            e_err = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        bit r, e, w, d, take;
        expected(r, e, w, d);
        take = hsel && htrans >= 2 && r;
        if (rst) begin
            m_phase = 0; m_held = 0; m_waits = 0;
            m_addr = '0; m_size = '0; m_write = 0;
        end else begin
            if (m_phase == 1) begin
                if (m_held) begin
                    if (!buffer_busy)
                        m_held = 0;
                    else begin
                        m_waits++;
                        if (m_waits == int'(MAX_W)) begin
                            m_phase = 2; m_held = 0;
                        end
                    end
                end else if (!r) begin
                    m_held = 1; m_waits = 0;
                end else
                    m_phase = 0;
            end else if (m_phase == 2)
                m_phase = 3;
            else if (m_phase == 3)
                m_phase = 0;
            if (take) begin
                m_addr = haddr; m_size = hsize; m_write = hwrite; m_held = 0;
                m_phase = is_illegal(int'(haddr), int'(hsize), hwrite) ? 2 : 1;
            end
        end
    end

    always @(negedge clk) begin
        bit r, e, w, d;
        if (model_on) begin
            expected(r, e, w, d);
            check("model hready", int'(hready), int'(r));
            check("model hresp", int'(hresp), int'(e));
            check("model wr_en", int'(wr_en), int'(w));
            check("model rd_en", int'(rd_en), int'(d));
            check("model haddr_reg", int'(haddr_reg), int'(m_addr));
            check("model hsize_reg", int'(hsize_reg), int'(m_size));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = '0; hsize = '0;
    endtask

    task automatic present(input bit s, input int t, input bit w, input int a, input int sz);
        hsel = s; htrans = 2'(t); hwrite = w; haddr = 4'(a); hsize = 2'(sz);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        buffer_busy = 1'b0;
        idle_in();
        step(); step();
        model_on = 1'b1;
        @(negedge clk);
        check("reset haddr_reg", int'(haddr_reg), 0);
        check("reset hsize_reg", int'(hsize_reg), 0);
        check("reset hready", int'(hready), 1);
        check("reset hresp", int'(hresp), 0);
        check("reset strobes", int'({wr_en, rd_en}), 0);
        step();
        rst = 1'b0;

        // Word write to 0.
        step(); present(1, 2, 1, 0, 2);
        step(); idle_in();
        @(negedge clk);
        check("wr0 haddr_reg", int'(haddr_reg), 0);
        check("wr0 hsize_reg", int'(hsize_reg), 2);
        check("wr0 wr_en", int'(wr_en), 1);
        check("wr0 hready/hresp", int'({hready, hresp}), 2);
        step(); @(negedge clk);
        check("wr0 wr_en one cycle", int'(wr_en), 0);

        // Write to read-only 4, then pipeline a byte read of 5 during the second error cycle.
        step(); present(1, 2, 1, 4, 2);
        step(); idle_in();
        @(negedge clk);
        check("ro err1 hready/hresp", int'({hready, hresp}), 1);
        check("ro err1 wr_en", int'(wr_en), 0);
        step(); present(1, 2, 0, 5, 0);
        @(negedge clk);
        check("ro err2 hready/hresp", int'({hready, hresp}), 3);
        check("ro err2 wr_en", int'(wr_en), 0);
        step(); idle_in();
        @(negedge clk);
        check("err2 pipelined rd_en", int'(rd_en), 1);
        check("err2 pipelined haddr_reg", int'(haddr_reg), 5);
        check("err2 pipelined hsize_reg", int'(hsize_reg), 0);

        // Read of 0 with the buffer busy for three cycles starting in the address phase.
        step(); present(1, 2, 0, 0, 2); buffer_busy = 1'b1;
        step(); idle_in();
        @(negedge clk); check("busy3 c1 hready", int'(hready), 0);
        step(); @(negedge clk); check("busy3 c2 hready", int'(hready), 0);
        step(); buffer_busy = 1'b0;
        @(negedge clk); check("busy3 c3 hready", int'({hready, rd_en}), 0);
        step(); @(negedge clk);
        check("busy3 release rd_en", int'(rd_en), 1);
        check("busy3 release hready", int'(hready), 1);

        // Buffer busy indefinitely: one stalled data cycle plus MAX_WAIT waits, then the error.
        step(); present(1, 2, 0, 1, 0); buffer_busy = 1'b1;
        step(); idle_in();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hresp) break;
            if (!hready && !rd_en) n++;
        end
        check("maxwait stall cycles", n, 16);
        check("maxwait err1", int'({hready, hresp}), 1);
        step(); @(negedge clk);
        check("maxwait err2", int'({hready, hresp}), 3);
        buffer_busy = 1'b0;

        // Back-to-back reads of C then D.
        step(); present(1, 2, 0, 12, 2);
        step(); present(1, 3, 0, 13, 2);
        @(negedge clk);
        check("b2b first haddr_reg", int'(haddr_reg), 12);
        check("b2b first rd/hready", int'({rd_en, hready}), 3);
        step(); idle_in();
        @(negedge clk);
        check("b2b second haddr_reg", int'(haddr_reg), 13);
        check("b2b second rd_en", int'(rd_en), 1);
        step(); @(negedge clk);
        check("b2b done rd_en", int'(rd_en), 0);

        // BUSY with hsel=1 and reads of illegal locations.
        step(); present(1, 1, 1, 0, 2);
        step(); present(1, 0, 0, 3, 1);
        @(negedge clk);
        check("busy htrans no strobe", int'({wr_en, rd_en, hresp}), 0);
        check("busy htrans holds haddr_reg", int'(haddr_reg), 13);
        step(); present(1, 2, 0, 10, 0);
        step(); present(1, 2, 0, 0, 3);
        @(negedge clk); check("addr A err1", int'({hready, hresp}), 1);
        step(); @(negedge clk); check("addr A err2", int'({hready, hresp}), 3);
        step(); idle_in();
        @(negedge clk); check("size 3 err1", int'({hready, hresp}), 1);
        step(); step();

        // Misaligned word read at 2.
        step(); present(1, 2, 0, 2, 2);
        step(); idle_in();
        @(negedge clk);
`ifdef AHB_SLAVE_MISALIGN_CHECK_EN
        check("misalign err1", int'({hready, hresp}), 1);
        check("misalign rd_en", int'(rd_en), 0);
`else
        check("misalign okay rd/hready/hresp", int'({rd_en, hready, hresp}), 6);
        check("misalign haddr_reg", int'(haddr_reg), 2);
`endif
        step(); step();

        // Reset during a wait.
        step(); present(1, 2, 0, 3, 2); buffer_busy = 1'b1;
        step(); idle_in();
        step(); step();
        @(negedge clk); check("pre-reset in wait", int'(hready), 0);
        step(); rst = 1'b1;
        step(); rst = 1'b0; buffer_busy = 1'b0;
        @(negedge clk);
        check("rst wait hready/hresp", int'({hready, hresp}), 2);
        check("rst wait regs", int'({haddr_reg, hsize_reg}), 0);
        check("rst wait strobes", int'({wr_en, rd_en}), 0);

        step(); step();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
